// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory arbiter client ports: default bus widths,
// read/write encoding and the request-buffer FSM state type.
package mem_port_pkg;

   localparam int DATA_W_DEF = 256;
   localparam int ADDR_W_DEF = 28;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } mem_port_state_e;

   // Width of an occupancy counter that must reach DEPTH itself.
   function automatic int count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous FIFO holding queued client requests.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   push, pop       enqueue / dequeue strobes (ignored when full / empty)
//   din, dout       entry in, head entry out (dout valid while !empty)
//   full, empty     occupancy flags
//   count           entries currently stored, 0..DEPTH
module mem_req_fifo
   import mem_port_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic [W-1:0]              din,
   output logic [W-1:0]              dout,
   output logic                      full,
   output logic                      empty,
   output logic [count_w(DEPTH)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = count_w(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mem_port_req_buffer.sv
// Request buffer in front of one arbiter client port. Queues client read/write
// requests, issues them in order on the mem_valid/mem_ready handshake, returns
// one response pulse per completion and flags stray completions.
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   req_valid/ready/rw/addr/wdata   client request side (ready = !full)
//   rsp_valid/rw/rdata              one-cycle response; rdata updates on reads only
//   fill_level                      queued entries including the one in issue
//   protocol_err                    sticky: mem_ready_data seen outside ISSUE
//   mem_valid_data/rw/addr/wr       registered request to arbiter
//   mem_ready_data, mem_data_rd     completion pulse and read data from arbiter
//
// state | meaning
// IDLE  | nothing in flight; issue head as soon as FIFO is non-empty
// ISSUE | request presented, mem_* held stable until mem_ready_data
// GAP   | one forced valid-low cycle after a completion
module mem_port_req_buffer
   import mem_port_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_rw,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [DATA_W-1:0]         req_wdata,
   output logic                      rsp_valid,
   output logic                      rsp_rw,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic [count_w(DEPTH)-1:0] fill_level,
   output logic                      protocol_err,
   output logic                      mem_valid_data,
   output logic                      mem_rw_data,
   output logic [ADDR_W-1:0]         mem_data_addr,
   output logic [DATA_W-1:0]         mem_data_wr,
   input  logic                      mem_ready_data,
   input  logic [DATA_W-1:0]         mem_data_rd
);

   localparam int ENT_W = 1 + ADDR_W + DATA_W;

   mem_port_state_e state, state_nxt;

   logic             push;
   logic             pop;
   logic             load_head;
   logic             err_set;
   logic             full;
   logic             empty;
   logic [ENT_W-1:0] head;
   logic             head_rw;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_wdata;

   // No pass-through: a full FIFO refuses the push even if a pop happens this edge.
   assign push      = req_valid & ~full;
   assign req_ready = ~full;
   assign {head_rw, head_addr, head_wdata} = head;

   mem_req_fifo #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({req_rw, req_addr, req_wdata}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (fill_level)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!empty) state_nxt = ST_ISSUE;
         ST_ISSUE: if (mem_ready_data) state_nxt = ST_GAP;
         ST_GAP:   state_nxt = empty ? ST_IDLE : ST_ISSUE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // In GAP the FIFO has already popped, so head is the next request.
   always_comb begin
      load_head = 1'b0;
      pop       = 1'b0;
      err_set   = 1'b0;
      case (state)
         ST_IDLE: begin
            load_head = ~empty;
            err_set   = mem_ready_data;
         end
         ST_ISSUE: pop = mem_ready_data;
         ST_GAP: begin
            load_head = ~empty;
            err_set   = mem_ready_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_valid_data <= 1'b0;
         mem_rw_data    <= RW_READ;
         mem_data_addr  <= '0;
         mem_data_wr    <= '0;
         rsp_valid      <= 1'b0;
         rsp_rw         <= RW_READ;
         rsp_rdata      <= '0;
         protocol_err   <= 1'b0;
      end else begin
         rsp_valid <= pop;
         if (load_head) begin
            mem_valid_data <= 1'b1;
            mem_rw_data    <= head_rw;
            mem_data_addr  <= head_addr;
            mem_data_wr    <= head_wdata;
         end else if (pop) begin
            mem_valid_data <= 1'b0;
         end
         if (pop) begin
            rsp_rw <= mem_rw_data;
            if (mem_rw_data == RW_READ) rsp_rdata <= mem_data_rd;
         end
         if (err_set) protocol_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_port_req_buffer.sv
module tb_mem_port_req_buffer;

   localparam int DATA_W = 256;
   localparam int ADDR_W = 28;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_rw;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_rw;
   logic [DATA_W-1:0] rsp_rdata;
   logic [2:0]        fill_level;
   logic              protocol_err;
   logic              mem_valid_data;
   logic              mem_rw_data;
   logic [ADDR_W-1:0] mem_data_addr;
   logic [DATA_W-1:0] mem_data_wr;
   logic              mem_ready_data;
   logic [DATA_W-1:0] mem_data_rd;

   int n_checks = 0;
   int n_errors = 0;

   logic [DATA_W-1:0] a5_data;
   logic [DATA_W-1:0] exp_rdata;
   logic [3:0]        jv;

   always #5 clk = ~clk;

   mem_port_req_buffer #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_rw         (req_rw),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_rw         (rsp_rw),
      .rsp_rdata      (rsp_rdata),
      .fill_level     (fill_level),
      .protocol_err   (protocol_err),
      .mem_valid_data (mem_valid_data),
      .mem_rw_data    (mem_rw_data),
      .mem_data_addr  (mem_data_addr),
      .mem_data_wr    (mem_data_wr),
      .mem_ready_data (mem_ready_data),
      .mem_data_rd    (mem_data_rd)
   );

   // Advance n rising edges, landing 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      a5_data        = {32{8'hA5}};
      rst            = 1'b0;
      req_valid      = 1'b0;
      req_rw         = 1'b0;
      req_addr       = '0;
      req_wdata      = '0;
      mem_ready_data = 1'b0;
      mem_data_rd    = '0;

      // 1 reset
      step(3);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_fill", fill_level, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rw", rsp_rw, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_perr", protocol_err, 0);
      chk("rst_mvalid", mem_valid_data, 0);
      chk("rst_mrw", mem_rw_data, 0);
      chk("rst_maddr", mem_data_addr, 0);
      chk("rst_mwr", mem_data_wr, 0);
      rst = 1'b1;
      step(1);

      // 2 single write
      req_valid = 1'b1; req_rw = 1'b1; req_addr = 28'h0000010; req_wdata = a5_data;
      step(1);
      req_valid = 1'b0;
      chk("wr_fill_e0", fill_level, 1);
      chk("wr_mvalid_e0", mem_valid_data, 0);
      step(1);
      chk("wr_mvalid_e1", mem_valid_data, 1);
      chk("wr_mrw", mem_rw_data, 1);
      chk("wr_maddr", mem_data_addr, 28'h0000010);
      chk("wr_mwr", mem_data_wr, a5_data);
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("wr_hold_valid", mem_valid_data, 1);
         chk("wr_hold_addr", mem_data_addr, 28'h0000010);
         chk("wr_hold_rsp", rsp_valid, 0);
      end
      mem_ready_data = 1'b1;
      step(1);
      mem_ready_data = 1'b0;
      chk("wr_rsp_valid", rsp_valid, 1);
      chk("wr_rsp_rw", rsp_rw, 1);
      chk("wr_rsp_rdata", rsp_rdata, 0);
      chk("wr_mvalid_done", mem_valid_data, 0);
      chk("wr_fill_done", fill_level, 0);
      step(1);
      chk("wr_rsp_pulse_end", rsp_valid, 0);

      // 3 single read
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 28'h0000020; req_wdata = '0;
      step(1);
      req_valid = 1'b0;
      step(1);
      chk("rd_mvalid", mem_valid_data, 1);
      chk("rd_mrw", mem_rw_data, 0);
      chk("rd_maddr", mem_data_addr, 28'h0000020);
      mem_data_rd = 256'h1234; mem_ready_data = 1'b1;
      step(1);
      mem_ready_data = 1'b0; mem_data_rd = '0;
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rsp_rw", rsp_rw, 0);
      chk("rd_rsp_rdata", rsp_rdata, 256'h1234);
      chk("rd_fill", fill_level, 0);
      exp_rdata = 256'h1234;
      step(1);

      // 4 fill: requests i have addr 0x100+i, rw=i[0], wdata=i+1
      for (int i = 0; i < 5; i++) begin
         jv = 4'(i);
         req_valid = 1'b1; req_rw = jv[0]; req_addr = ADDR_W'(28'h100 + i);
         req_wdata = DATA_W'(i + 1);
         step(1);
      end
      chk("fill_level_full", fill_level, 4);
      chk("fill_ready_low", req_ready, 0);
      chk("fill_mvalid", mem_valid_data, 1);
      chk("fill_maddr0", mem_data_addr, 28'h100);
      for (int j = 0; j < 4; j++) begin
         jv = 4'(j);
         step(2);
         mem_data_rd = DATA_W'(j + 16); mem_ready_data = 1'b1;
         step(1);
         mem_ready_data = 1'b0; mem_data_rd = '0;
         if (jv[0] == 1'b0) exp_rdata = DATA_W'(j + 16);
         chk("fill_rsp_valid", rsp_valid, 1);
         chk("fill_rsp_rw", rsp_rw, jv[0]);
         chk("fill_rsp_rdata", rsp_rdata, exp_rdata);
         chk("fill_gap_valid", mem_valid_data, 0);
         if (j == 0) begin
            chk("fill_after_pop", fill_level, 3);
            chk("fill_ready_back", req_ready, 1);
         end
         step(1);
         req_valid = 1'b0;
         chk("fill_reissue_valid", mem_valid_data, 1);
         chk("fill_reissue_addr", mem_data_addr, ADDR_W'(28'h100 + j + 1));
         chk("fill_reissue_wr", mem_data_wr, DATA_W'(j + 2));
         chk("fill_rsp_end", rsp_valid, 0);
         if (j == 0) chk("fill_fifth_pushed", fill_level, 4);
      end
      chk("fill_last_level", fill_level, 1);
      mem_data_rd = 256'hBEEF; mem_ready_data = 1'b1;
      step(1);
      mem_ready_data = 1'b0; mem_data_rd = '0;
      chk("fill_last_rsp", rsp_valid, 1);
      chk("fill_last_rdata", rsp_rdata, 256'hBEEF);
      chk("fill_empty", fill_level, 0);
      step(2);

      // 5 spurious ready in IDLE
      chk("spur_perr_before", protocol_err, 0);
      mem_ready_data = 1'b1;
      step(1);
      mem_ready_data = 1'b0;
      chk("spur_perr", protocol_err, 1);
      chk("spur_no_rsp", rsp_valid, 0);
      step(3);
      chk("spur_perr_sticky", protocol_err, 1);
      chk("spur_no_rsp_later", rsp_valid, 0);

      // 6 reset mid-ISSUE
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      chk("rst2_perr_clear", protocol_err, 0);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 28'h0000030;
      step(1);
      req_valid = 1'b0;
      step(1);
      chk("mid_mvalid", mem_valid_data, 1);
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      chk("mid_mvalid_drop", mem_valid_data, 0);
      chk("mid_no_rsp", rsp_valid, 0);
      chk("mid_fill", fill_level, 0);
      chk("mid_perr", protocol_err, 0);
      step(1);
      chk("mid_idle_valid", mem_valid_data, 0);
      mem_ready_data = 1'b1;
      step(1);
      mem_ready_data = 1'b0;
      chk("late_ready_perr", protocol_err, 1);
      chk("late_ready_no_rsp", rsp_valid, 0);
      chk("late_ready_valid", mem_valid_data, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
